// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions.
//   RESP_* : RRESP/BRESP encodings.
//   axil_rd_state_e : read-responder FSM states.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } axil_rd_state_e;

endpackage

// File: rtl/axil_rd_responder.sv
// AXI4-Lite read-channel responder (AR and R, slave side).
// Accepts one read address at a time, issues a single-cycle read strobe to a word-addressed
// register file with fixed latency RD_LAT, and returns the word on R. Word indices at or above
// NUM_REGS answer SLVERR with zero data and never touch the register file.
//
// Ports:
//   AXI_ACLK, AXI_ARESETN        clock, asynchronous active-low reset
//   AXI_ARADDR/ARPROT/ARVALID    read address channel in (ARPROT ignored)
//   AXI_ARREADY                  read address ready (registered)
//   AXI_RDATA/RRESP/RVALID       read data channel out (registered, stable while RVALID)
//   AXI_RREADY                   read data ready
//   reg_rd_en, reg_rd_addr       register-file read strobe and word index (registered)
//   reg_rd_data                  register-file data, valid RD_LAT cycles after reg_rd_en
module axil_rd_responder
  import axil_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESETN,
  input  logic [ADDR_W-1:0]           AXI_ARADDR,
  input  logic [2:0]                  AXI_ARPROT,
  input  logic                        AXI_ARVALID,
  output logic                        AXI_ARREADY,
  output logic [DATA_W-1:0]           AXI_RDATA,
  output logic [1:0]                  AXI_RRESP,
  output logic                        AXI_RVALID,
  input  logic                        AXI_RREADY,
  output logic                        reg_rd_en,
  output logic [$clog2(NUM_REGS)-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0]           reg_rd_data
);

  localparam int unsigned OffW = $clog2(DATA_W / 8);
  localparam int unsigned IdxW = ADDR_W - OffW;
  localparam int unsigned RaW  = $clog2(NUM_REGS);
  localparam int unsigned CntW = $clog2(RD_LAT + 1);
  // One extra bit so NUM_REGS == 2**IdxW does not wrap to zero.
  localparam logic [IdxW:0] NumRegsW = (IdxW + 1)'(NUM_REGS);

  if (RD_LAT < 1) begin : gen_chk_lat
    $error("axil_rd_responder: RD_LAT must be >= 1");
  end
  if (!(DATA_W == 32 || DATA_W == 64)) begin : gen_chk_dw
    $error("axil_rd_responder: DATA_W must be 32 or 64");
  end
  if (NUM_REGS < 2 || NUM_REGS > 2 ** IdxW) begin : gen_chk_regs
    $error("axil_rd_responder: NUM_REGS must be in [2, 2**(ADDR_W-$clog2(DATA_W/8))]");
  end

  axil_rd_state_e    state_q;
  logic [CntW-1:0]   cnt_q;
  logic              init_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              rd_en_q;
  logic [RaW-1:0]    rd_addr_q;

  logic [IdxW-1:0] ar_idx;
  logic            ar_in_range;
  logic            unused_sig;

  assign ar_idx      = AXI_ARADDR[ADDR_W-1:OffW];
  assign ar_in_range = {1'b0, ar_idx} < NumRegsW;
  assign unused_sig  = ^{AXI_ARPROT, AXI_ARADDR[OffW-1:0]};

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      init_q    <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      // init_q holds ARREADY low for the first clock after reset release.
      init_q  <= 1'b1;
      rd_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (AXI_ARVALID && arready_q) begin
            arready_q <= 1'b0;
            if (ar_in_range) begin
              state_q   <= WAIT;
              rd_en_q   <= 1'b1;
              rd_addr_q <= RaW'(ar_idx);
              cnt_q     <= CntW'(RD_LAT);
            end else begin
              state_q  <= RESP;
              rvalid_q <= 1'b1;
              rresp_q  <= RESP_SLVERR;
              rdata_q  <= '0;
            end
          end else begin
            arready_q <= init_q;
          end
        end
        WAIT: begin
          // Counter reaches zero in the cycle reg_rd_data is valid.
          if (cnt_q == '0) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= reg_rd_data;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        RESP: begin
          if (AXI_RREADY) begin
            state_q   <= IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          rvalid_q  <= 1'b0;
          arready_q <= 1'b0;
        end
      endcase
    end
  end

  assign AXI_ARREADY = arready_q;
  assign AXI_RVALID  = rvalid_q;
  assign AXI_RDATA   = rdata_q;
  assign AXI_RRESP   = rresp_q;
  assign reg_rd_en   = rd_en_q;
  assign reg_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_axil_rd_responder.sv
// Bench for axil_rd_responder: dut0 has RD_LAT=1, dut1 has RD_LAT=3, both 32-bit, 16 regs.
module tb_axil_rd_responder;

  localparam int NR = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  arprot;
  logic [11:0] araddr  [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] rdata   [2];
  logic [1:0]  rresp   [2];
  logic        rvalid  [2];
  logic        rready  [2];
  logic        en      [2];
  logic [3:0]  rd_addr [2];
  logic [31:0] rd_data [2];

  logic [31:0] mem [2][NR];
  logic [31:0] pipe0;
  logic [31:0] pipe1 [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_rd_responder #(.DATA_W(32), .ADDR_W(12), .NUM_REGS(16), .RD_LAT(1)) u_dut0 (
    .AXI_ACLK   (clk),
    .AXI_ARESETN(rst_n),
    .AXI_ARADDR (araddr[0]),
    .AXI_ARPROT (arprot),
    .AXI_ARVALID(arvalid[0]),
    .AXI_ARREADY(arready[0]),
    .AXI_RDATA  (rdata[0]),
    .AXI_RRESP  (rresp[0]),
    .AXI_RVALID (rvalid[0]),
    .AXI_RREADY (rready[0]),
    .reg_rd_en  (en[0]),
    .reg_rd_addr(rd_addr[0]),
    .reg_rd_data(rd_data[0])
  );

  axil_rd_responder #(.DATA_W(32), .ADDR_W(12), .NUM_REGS(16), .RD_LAT(3)) u_dut1 (
    .AXI_ACLK   (clk),
    .AXI_ARESETN(rst_n),
    .AXI_ARADDR (araddr[1]),
    .AXI_ARPROT (arprot),
    .AXI_ARVALID(arvalid[1]),
    .AXI_ARREADY(arready[1]),
    .AXI_RDATA  (rdata[1]),
    .AXI_RRESP  (rresp[1]),
    .AXI_RVALID (rvalid[1]),
    .AXI_RREADY (rready[1]),
    .reg_rd_en  (en[1]),
    .reg_rd_addr(rd_addr[1]),
    .reg_rd_data(rd_data[1])
  );

  // Register-file models: data for a strobe appears exactly RD_LAT cycles later, junk otherwise.
  always @(posedge clk) begin
    pipe0    <= en[0] ? mem[0][rd_addr[0]] : $urandom();
    pipe1[0] <= en[1] ? mem[1][rd_addr[1]] : $urandom();
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign rd_data[0] = pipe0;
  assign rd_data[1] = pipe1[2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Issues one read on dut d (called at a negedge) and records what happened, cycle numbers
  // counted from the AR handshake cycle (0).
  task automatic run_read(input int d, input logic [11:0] addr, input int hold, input bit keep_ar,
                          output int rv_cyc, output int hs_cyc, output logic [31:0] data,
                          output logic [1:0] resp, output int en_cnt, output int en_cyc,
                          output logic [3:0] en_addr, output int unstable, output int ar_busy,
                          output logic ar_after, output logic rv_after);
    rv_cyc = -1; hs_cyc = -1; data = '0; resp = '0; en_cnt = 0; en_cyc = -1; en_addr = '0;
    unstable = 0; ar_busy = 0; ar_after = 1'b0; rv_after = 1'b1;
    for (int w = 0; w < 20 && arready[d] !== 1'b1; w++) @(negedge clk);
    if (arready[d] !== 1'b1) return;
    arvalid[d] = 1'b1;
    araddr[d]  = addr;
    rready[d]  = (hold == 0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (hs_cyc >= 0) begin
        ar_after = arready[d];
        rv_after = rvalid[d];
        break;
      end
      if (!keep_ar) arvalid[d] = 1'b0;
      if (arready[d] === 1'b1) ar_busy++;
      if (en[d] === 1'b1) begin
        en_cnt++;
        en_cyc  = k;
        en_addr = rd_addr[d];
      end
      if (rv_cyc >= 0) begin
        if (rvalid[d] !== 1'b1 || rdata[d] !== data || rresp[d] !== resp) unstable++;
      end else if (rvalid[d] === 1'b1) begin
        rv_cyc = k;
        data   = rdata[d];
        resp   = rresp[d];
      end
      if (rv_cyc >= 0 && k - rv_cyc >= hold) rready[d] = 1'b1;
      if (rvalid[d] === 1'b1 && rready[d] === 1'b1) begin
        hs_cyc     = k;
        arvalid[d] = 1'b0;
      end
    end
    arvalid[d] = 1'b0;
    rready[d]  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      arvalid[d] = 1'b0; rready[d] = 1'b1; araddr[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (arready[d] !== 1'b0 || rvalid[d] !== 1'b0 || en[d] !== 1'b0) begin
        errors++;
        $display("FAIL rst_ctrl d%0d got ar=%b rv=%b en=%b exp 0 0 0", d, arready[d], rvalid[d],
                 en[d]);
      end
      checks++;
      if (rdata[d] !== 32'h0 || rresp[d] !== 2'b00 || rd_addr[d] !== 4'h0) begin
        errors++;
        $display("FAIL rst_data d%0d got rdata=%h rresp=%b addr=%h exp 0", d, rdata[d],
                 rresp[d], rd_addr[d]);
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (arready[d] !== (c >= 2) || rvalid[d] !== 1'b0 || en[d] !== 1'b0) begin
          errors++;
          $display("FAIL rel_c%0d d%0d got ar=%b rv=%b en=%b exp %b 0 0", c, d, arready[d],
                   rvalid[d], en[d], c >= 2);
        end
      end
    end
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      for (int d = 0; d < 2; d++) begin
        araddr[d] = 12'($urandom());
        rready[d] = 1'($urandom());
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        if (arready[d] !== 1'b1 || rvalid[d] !== 1'b0 || en[d] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_quiet got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_in_range();
    int rv, hs, ec, ecyc, unst, arb;
    logic [31:0] dat; logic [1:0] rsp; logic [3:0] ea; logic ara, rva;
    run_read(0, 12'h008, 0, 1'b0, rv, hs, dat, rsp, ec, ecyc, ea, unst, arb, ara, rva);
    checks++;
    if (ec !== 1 || ecyc !== 1 || ea !== 4'd2) begin
      errors++;
      $display("FAIL inr_strobe got cnt=%0d cyc=%0d addr=%0d exp 1 1 2", ec, ecyc, ea);
    end
    checks++;
    if (rv !== 3) begin errors++; $display("FAIL inr_rv_cyc got %0d exp 3", rv); end
    checks++;
    if (dat !== 32'hDEADBEEF || rsp !== 2'b00) begin
      errors++;
      $display("FAIL inr_data got %h/%b exp deadbeef/00", dat, rsp);
    end
    checks++;
    if (arb !== 0 || ara !== 1'b1 || rva !== 1'b0) begin
      errors++;
      $display("FAIL inr_after got busy=%0d ar=%b rv=%b exp 0 1 0", arb, ara, rva);
    end
  endtask

  task automatic test_out_of_range();
    int rv, hs, ec, ecyc, unst, arb;
    logic [31:0] dat; logic [1:0] rsp; logic [3:0] ea; logic ara, rva;
    run_read(0, 12'h040, 0, 1'b0, rv, hs, dat, rsp, ec, ecyc, ea, unst, arb, ara, rva);
    checks++;
    if (ec !== 0) begin errors++; $display("FAIL oor_strobe got %0d exp 0", ec); end
    checks++;
    if (rv !== 1) begin errors++; $display("FAIL oor_rv_cyc got %0d exp 1", rv); end
    checks++;
    if (dat !== 32'h0 || rsp !== 2'b10) begin
      errors++;
      $display("FAIL oor_resp got %h/%b exp 0/10", dat, rsp);
    end
    checks++;
    if (ara !== 1'b1 || rva !== 1'b0) begin
      errors++;
      $display("FAIL oor_after got ar=%b rv=%b exp 1 0", ara, rva);
    end
  endtask

  task automatic test_rready_hold();
    int rv, hs, ec, ecyc, unst, arb;
    logic [31:0] dat; logic [1:0] rsp; logic [3:0] ea; logic ara, rva;
    run_read(0, 12'h014, 7, 1'b1, rv, hs, dat, rsp, ec, ecyc, ea, unst, arb, ara, rva);
    checks++;
    if (rv !== 3 || hs !== 10) begin
      errors++;
      $display("FAIL hold_timing got rv=%0d hs=%0d exp 3 10", rv, hs);
    end
    checks++;
    if (unst !== 0 || arb !== 0) begin
      errors++;
      $display("FAIL hold_stable got unstable=%0d arready_busy=%0d exp 0 0", unst, arb);
    end
    checks++;
    if (dat !== mem[0][5] || rsp !== 2'b00) begin
      errors++;
      $display("FAIL hold_data got %h/%b exp %h/00", dat, rsp, mem[0][5]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int rc [2];
    logic [31:0] rdv [2];
    n = 0; rc[0] = -1; rc[1] = -1; rdv[0] = '0; rdv[1] = '0;
    for (int w = 0; w < 20 && arready[1] !== 1'b1; w++) @(negedge clk);
    arvalid[1] = 1'b1; araddr[1] = 12'h004; rready[1] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) araddr[1] = 12'h008;
      if (rvalid[1] === 1'b1 && n < 2) begin
        rc[n]  = k;
        rdv[n] = rdata[1];
        n++;
        if (n == 2) begin
          arvalid[1] = 1'b0;
          break;
        end
      end
    end
    arvalid[1] = 1'b0;
    checks++;
    if (n !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", n); end
    checks++;
    if (rc[0] !== 5 || rc[1] - rc[0] !== 6) begin
      errors++;
      $display("FAIL b2b_timing got first=%0d gap=%0d exp 5 6", rc[0], rc[1] - rc[0]);
    end
    checks++;
    if (rdv[0] !== mem[1][1] || rdv[1] !== mem[1][2]) begin
      errors++;
      $display("FAIL b2b_data got %h %h exp %h %h", rdv[0], rdv[1], mem[1][1], mem[1][2]);
    end
  endtask

  task automatic test_random();
    int rv, hs, ec, ecyc, unst, arb, d, hold, idx, exp_rv;
    logic [31:0] dat, exp_dat; logic [1:0] rsp, exp_rsp; logic [3:0] ea; logic ara, rva;
    logic [11:0] addr;
    for (int it = 0; it < 24; it++) begin
      d    = int'($urandom_range(0, 1));
      hold = int'($urandom_range(0, 3));
      addr = 12'($urandom_range(0, 127));
      arprot = 3'($urandom());
      mem[d][$urandom_range(0, NR - 1)] = $urandom();
      idx = int'(addr) / 4;
      if (idx < NR) begin
        exp_rv = lat_of(d) + 2; exp_dat = mem[d][idx]; exp_rsp = 2'b00;
      end else begin
        exp_rv = 1; exp_dat = 32'h0; exp_rsp = 2'b10;
      end
      run_read(d, addr, hold, 1'b0, rv, hs, dat, rsp, ec, ecyc, ea, unst, arb, ara, rva);
      checks++;
      if (rv !== exp_rv || hs !== exp_rv + hold) begin
        errors++;
        $display("FAIL rnd%0d_timing d%0d a=%h got rv=%0d hs=%0d exp %0d %0d", it, d, addr, rv,
                 hs, exp_rv, exp_rv + hold);
      end
      checks++;
      if (dat !== exp_dat || rsp !== exp_rsp || unst !== 0) begin
        errors++;
        $display("FAIL rnd%0d_data d%0d a=%h got %h/%b unst=%0d exp %h/%b", it, d, addr, dat,
                 rsp, unst, exp_dat, exp_rsp);
      end
      checks++;
      if (ec !== (idx < NR ? 1 : 0) || (idx < NR && 32'(ea) !== 32'(idx))) begin
        errors++;
        $display("FAIL rnd%0d_strobe d%0d a=%h got cnt=%0d addr=%0d exp %0d", it, d, addr, ec,
                 ea, idx);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad, rv, hs, ec, ecyc, unst, arb;
    logic [31:0] dat; logic [1:0] rsp; logic [3:0] ea; logic ara, rva;
    for (int w = 0; w < 20 && arready[1] !== 1'b1; w++) @(negedge clk);
    arvalid[1] = 1'b1; araddr[1] = 12'h00C; rready[1] = 1'b1;
    @(negedge clk);
    arvalid[1] = 1'b0;
    checks++;
    if (en[1] !== 1'b1) begin errors++; $display("FAIL rmid_strobe got %b exp 1", en[1]); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({arready[d], rvalid[d], rdata[d], rresp[d], en[d], rd_addr[d]} !== 41'h0) begin
        errors++;
        $display("FAIL rmid_clear d%0d got ar=%b rv=%b rdata=%h rresp=%b en=%b addr=%h exp 0", d,
                 arready[d], rvalid[d], rdata[d], rresp[d], en[d], rd_addr[d]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rvalid[0] !== 1'b0 || rvalid[1] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rmid_stale got %0d exp 0", bad); end
    run_read(1, 12'h014, 0, 1'b0, rv, hs, dat, rsp, ec, ecyc, ea, unst, arb, ara, rva);
    checks++;
    if (rv !== 5 || dat !== mem[1][5] || rsp !== 2'b00) begin
      errors++;
      $display("FAIL rmid_next got rv=%0d %h/%b exp 5 %h/00", rv, dat, rsp, mem[1][5]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    arprot = 3'b000;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NR; i++) mem[d][i] = $urandom();
    mem[0][2] = 32'hDEADBEEF;
    test_reset();
    test_idle();
    test_in_range();
    test_out_of_range();
    test_rready_hold();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
